cache_ctrl_sa: RTL and testbench

Parametrised, synthesizable read-only cache controller: set-associative (1 or 2 ways), configurable line size and depth, with hit/miss statistics counters. It sits between a word-addressed requester and a slower main-memory port. On a miss it refills a full line by burst and returns the requested word. It replaces the earlier behavioural direct-mapped hit-rate model with clocked, handshaked hardware that includes LRU replacement.

---
 rtl/cache_ctrl_sa.sv | 203 ++++++++++++++++++++
 tb/tb_cache_ctrl_sa.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_sa.sv
// Read-only set-associative cache controller (1 or 2 ways) with burst line refill,
// per-set LRU replacement and saturating hit/miss statistics counters.
module cache_ctrl_sa #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 15,
    parameter int INDEX_W    = 10,
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 2,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int WORDS = SETS * LINE_WORDS;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_REFILL  = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [DATA_W-1:0] data_mem [WAYS][WORDS];

    logic [1:0]                 state_q, state_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic                       victim_q, victim_d;
    logic [OFF_W-1:0]           beat_q, beat_d;
    logic [WAYS-1:0][SETS-1:0]  valid_q, valid_d;
    logic [SETS-1:0]            lru_q, lru_d;
    logic                       ready_q, ready_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic                       mreq_q, mreq_d;
    logic [ADDR_W-1:0]          maddr_q, maddr_d;
    logic [CNT_W-1:0]           hit_q, hit_d;
    logic [CNT_W-1:0]           miss_q, miss_d;

    logic [OFF_W-1:0]   off;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WAYS-1:0]    way_hit;
    logic               hit;
    logic               hit_way;
    logic               victim_sel;
    logic               data_we;
    logic               tag_we;

    assign off = addr_q[OFF_W-1:0];
    assign idx = addr_q[OFF_W+INDEX_W-1:OFF_W];
    assign tag = addr_q[ADDR_W-1 -: TAG_W];

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = valid_q[w][idx] && (tag_mem[w][idx] == tag);
        end
    end

    assign hit = |way_hit;

    always_comb begin
        hit_way = 1'b0;
        if (WAYS == 2 && way_hit[WAYS-1]) hit_way = 1'b1;
    end

    // Fill an empty way first (way 0 before way 1); evict the LRU way only when the set is full.
    always_comb begin
        victim_sel = 1'b0;
        if (WAYS == 2) begin
            if (!valid_q[0][idx])           victim_sel = 1'b0;
            else if (!valid_q[WAYS-1][idx]) victim_sel = 1'b1;
            else                            victim_sel = lru_q[idx];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        victim_d = victim_q;
        beat_d   = beat_q;
        valid_d  = valid_q;
        lru_d    = lru_q;
        ready_d  = 1'b0;
        rdata_d  = rdata_q;
        mreq_d   = mreq_q;
        maddr_d  = maddr_q;
        data_we  = 1'b0;
        tag_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    lru_d[idx] = ~hit_way;
                    rdata_d    = data_mem[hit_way][{idx, off}];
                    ready_d    = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    victim_d = victim_sel;
                    beat_d   = '0;
                    mreq_d   = 1'b1;
                    maddr_d  = {tag, idx, {OFF_W{1'b0}}};
                    state_d  = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                    if (beat_q == off) rdata_d = mem_rdata;
                    if (beat_q == LAST_BEAT) begin
                        tag_we                  = 1'b1;
                        valid_d[victim_q][idx]  = 1'b1;
                        lru_d[idx]              = ~victim_q;
                        beat_d                  = '0;
                        mreq_d                  = 1'b0;
                        ready_d                 = 1'b1;
                        state_d                 = S_RESP;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (stat_clr) begin
            hit_d  = '0;
            miss_d = '0;
        end else if (state_q == S_COMPARE) begin
            if (hit && hit_q != CNT_MAX)        hit_d  = hit_q + CNT_W'(1);
            else if (!hit && miss_q != CNT_MAX) miss_d = miss_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            victim_q <= 1'b0;
            beat_q   <= '0;
            valid_q  <= '0;
            lru_q    <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            mreq_q   <= 1'b0;
            maddr_q  <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            beat_q   <= beat_d;
            valid_q  <= valid_d;
            lru_q    <= lru_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            mreq_q   <= mreq_d;
            maddr_q  <= maddr_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_mem[victim_q][{idx, beat_q}] <= mem_rdata;
        if (tag_we)  tag_mem[victim_q][idx] <= tag;
    end

    assign cpu_ready  = ready_q;
    assign cpu_rdata  = rdata_q;
    assign mem_req    = mreq_q;
    assign mem_addr   = maddr_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_ctrl_sa.sv
// Directed bench for cache_ctrl_sa: default 2-way instance, a 1-way instance and a
// 4-bit-counter instance, each served by its own refill responder.
module tb_cache_ctrl_sa;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stat_clr = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [2:0]  req_v = '0;
    logic [2:0]  ready_v;
    logic [2:0]  mreq_v;
    logic [2:0]  rvalid_v;
    logic [31:0] rdata_v  [3];
    logic [14:0] maddr_v  [3];
    logic [31:0] mrdata_v [3];
    int          gap_v    [3];
    logic [31:0] hc0, mc0, hc1, mc1;
    logic [3:0]  hc2, mc2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cache_ctrl_sa dut0 (
        .clk(clk), .rst(rst), .cpu_req(req_v[0]), .cpu_addr(cpu_addr),
        .cpu_ready(ready_v[0]), .cpu_rdata(rdata_v[0]),
        .mem_req(mreq_v[0]), .mem_addr(maddr_v[0]),
        .mem_rvalid(rvalid_v[0]), .mem_rdata(mrdata_v[0]),
        .stat_clr(stat_clr), .hit_count(hc0), .miss_count(mc0));

    cache_ctrl_sa #(.WAYS(1)) dut1 (
        .clk(clk), .rst(rst), .cpu_req(req_v[1]), .cpu_addr(cpu_addr),
        .cpu_ready(ready_v[1]), .cpu_rdata(rdata_v[1]),
        .mem_req(mreq_v[1]), .mem_addr(maddr_v[1]),
        .mem_rvalid(rvalid_v[1]), .mem_rdata(mrdata_v[1]),
        .stat_clr(stat_clr), .hit_count(hc1), .miss_count(mc1));

    cache_ctrl_sa #(.CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .cpu_req(req_v[2]), .cpu_addr(cpu_addr),
        .cpu_ready(ready_v[2]), .cpu_rdata(rdata_v[2]),
        .mem_req(mreq_v[2]), .mem_addr(maddr_v[2]),
        .mem_rvalid(rvalid_v[2]), .mem_rdata(mrdata_v[2]),
        .stat_clr(stat_clr), .hit_count(hc2), .miss_count(mc2));

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return ({17'd0, a} * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each beat is preceded by gap_v[k] idle cycles while mem_req is high.
    initial begin
        int beat [3];
        int w    [3];
        rvalid_v = '0;
        for (int k = 0; k < 3; k++) begin
            mrdata_v[k] = '0;
            gap_v[k]    = 0;
            beat[k]     = 0;
            w[k]        = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst || !mreq_v[k]) begin
                    rvalid_v[k] = 1'b0;
                    beat[k] = 0;
                    w[k] = 0;
                end else if (w[k] >= gap_v[k]) begin
                    rvalid_v[k] = 1'b1;
                    mrdata_v[k] = mem_word(maddr_v[k] + 15'(beat[k]));
                    beat[k]++;
                    w[k] = 0;
                end else begin
                    rvalid_v[k] = 1'b0;
                    w[k]++;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // lat / mlat are cycle numbers after the accept edge of cpu_ready / first mem_req.
    task automatic do_req(input int k, input logic [14:0] a, output int lat,
                          output logic [31:0] data, output logic [14:0] maddr, output int mlat);
        lat = 0; mlat = 0; data = '0; maddr = '0;
        @(negedge clk);
        cpu_addr = a;
        req_v[k] = 1'b1;
        @(posedge clk);
        #1 cpu_addr = a ^ 15'h7FFF;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (mreq_v[k] && mlat == 0) begin
                mlat = n;
                maddr = maddr_v[k];
            end
            if (ready_v[k]) begin
                lat = n;
                data = rdata_v[k];
                break;
            end
        end
        req_v[k] = 1'b0;
        if (lat == 0) check_eq("req_timeout", {63'd0, ready_v[k]}, 64'd1);
    endtask

    initial begin
        int lat, mlat, errs_before;
        logic [31:0] data;
        logic [14:0] maddr;
        logic [14:0] seq_addr [6];
        int          seq_lat  [6];

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_ready", {63'd0, ready_v[0]}, 64'd0);
        check_eq("rst_rdata", {32'd0, rdata_v[0]}, 64'd0);
        check_eq("rst_mreq", {63'd0, mreq_v[0]}, 64'd0);
        check_eq("rst_maddr", {49'd0, maddr_v[0]}, 64'd0);
        check_eq("rst_hits", {32'd0, hc0}, 64'd0);
        check_eq("rst_misses", {32'd0, mc0}, 64'd0);

        // Sequential sweep: one miss then three hits per 4-word line.
        errs_before = n_errors;
        for (int a = 1024; a <= 9215; a++) begin
            do_req(0, 15'(a), lat, data, maddr, mlat);
            check_eq("sweep_rdata", {32'd0, data}, {32'd0, mem_word(15'(a))});
            check_eq("sweep_lat", 64'(lat), (a % 4 == 0) ? 64'd6 : 64'd2);
            if (n_errors - errs_before > 10) break;
        end
        check_eq("sweep_hits", {32'd0, hc0}, 64'd6144);
        check_eq("sweep_misses", {32'd0, mc0}, 64'd2048);

        // Two-way LRU on set 0: miss, miss, hit, miss (evicts 0x1000), hit, miss.
        apply_reset();
        seq_addr = '{15'h0000, 15'h1000, 15'h0000, 15'h2000, 15'h0000, 15'h1000};
        seq_lat  = '{6, 6, 2, 6, 2, 6};
        for (int i = 0; i < 6; i++) begin
            do_req(0, seq_addr[i], lat, data, maddr, mlat);
            check_eq($sformatf("lru_lat%0d", i), 64'(lat), 64'(seq_lat[i]));
            check_eq($sformatf("lru_rdata%0d", i), {32'd0, data}, {32'd0, mem_word(seq_addr[i])});
        end
        check_eq("lru_hits", {32'd0, hc0}, 64'd2);
        check_eq("lru_misses", {32'd0, mc0}, 64'd4);

        // Beats at accept+4, +7, +10, +13 (two idle cycles before each) -> ready at +14.
        gap_v[0] = 2;
        do_req(0, 15'h0103, lat, data, maddr, mlat);
        gap_v[0] = 0;
        check_eq("gap_lat", 64'(lat), 64'd14);
        check_eq("gap_rdata", {32'd0, data}, {32'd0, mem_word(15'h0103)});
        check_eq("gap_maddr", {49'd0, maddr}, 64'h0100);
        check_eq("gap_mreq_lat", 64'(mlat), 64'd2);

        // Direct-mapped instance: every access to the shared set misses.
        seq_addr[0] = 15'h0000; seq_addr[1] = 15'h1000; seq_addr[2] = 15'h0000;
        for (int i = 0; i < 3; i++) begin
            do_req(1, seq_addr[i], lat, data, maddr, mlat);
            check_eq($sformatf("dm_lat%0d", i), 64'(lat), 64'd6);
            check_eq($sformatf("dm_maddr%0d", i), {49'd0, maddr}, {49'd0, seq_addr[i]});
            check_eq($sformatf("dm_rdata%0d", i), {32'd0, data}, {32'd0, mem_word(seq_addr[i])});
        end
        check_eq("dm_misses", {32'd0, mc1}, 64'd3);
        check_eq("dm_hits", {32'd0, hc1}, 64'd0);

        // Reset after beat 2 of a refill; the partial line must not become valid.
        apply_reset();
        @(negedge clk);
        cpu_addr = 15'h0202;
        req_v[0] = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        req_v[0] = 1'b0;
        #1 check_eq("rst_refill_mreq", {63'd0, mreq_v[0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_req(0, 15'h0202, lat, data, maddr, mlat);
        check_eq("rerq_lat", 64'(lat), 64'd6);
        check_eq("rerq_rdata", {32'd0, data}, {32'd0, mem_word(15'h0202)});
        check_eq("rerq_misses", {32'd0, mc0}, 64'd1);
        check_eq("rerq_hits", {32'd0, hc0}, 64'd0);

        // 4-bit counters: saturation, then clear during a hit's COMPARE cycle.
        do_req(2, 15'h0040, lat, data, maddr, mlat);
        check_eq("sat_first_miss", {60'd0, mc2}, 64'd1);
        for (int i = 0; i < 20; i++) do_req(2, 15'h0041 + 15'(i % 3), lat, data, maddr, mlat);
        check_eq("sat_hits", {60'd0, hc2}, 64'd15);
        check_eq("sat_misses", {60'd0, mc2}, 64'd1);
        @(negedge clk);
        cpu_addr = 15'h0042;
        req_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        req_v[2] = 1'b0;
        check_eq("clr_ready", {63'd0, ready_v[2]}, 64'd1);
        check_eq("clr_hits", {60'd0, hc2}, 64'd0);
        check_eq("clr_misses", {60'd0, mc2}, 64'd0);
        do_req(2, 15'h0043, lat, data, maddr, mlat);
        check_eq("post_clr_hits", {60'd0, hc2}, 64'd1);
        check_eq("post_clr_rdata", {32'd0, data}, {32'd0, mem_word(15'h0043)});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
